// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Brief    : Field-bundle / instruction-memory bus for the RV32I encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  // Session control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  // Field bundle handshake
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  // Instruction-memory write side and status
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  // Encoder side
  modport slave (
    input  start, base_addr, count, in_valid, fmt, opcode, rd, rs1, rs2,
           funct3, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  // Loader / producer side
  modport master (
    output start, base_addr, count, in_valid, fmt, opcode, rd, rs1, rs2,
           funct3, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Packs decoded RV32I fields into instruction words and writes
//             them sequentially into instruction memory from a base address.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  instr_encoder_if.slave   bus_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_PTR_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_CNT_ZERO = '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;
  logic              we_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              w_busy;
  logic              w_start;
  logic              w_accept;
  logic              w_last;
  logic              w_legal;
  logic [31:0]       w_word;

  assign w_busy   = (state_q == ST_LOAD);
  // start is only honoured between sessions
  assign w_start  = bus_if.start && (state_q != ST_LOAD);
  // a zero-length session never takes a beat even though ready is up
  assign w_accept = bus_if.in_valid && w_busy && (count_q != c_CNT_ZERO);
  assign w_last   = ((cnt_q + c_CNT_ONE) == count_q);

  // Field packing and immediate range legality for the presented bundle
  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b0;
    case (bus_if.fmt)
      3'd0: begin // R
        w_legal = 1'b1;
        w_word  = {bus_if.funct7, bus_if.rs2, bus_if.rs1, bus_if.funct3,
                   bus_if.rd, bus_if.opcode};
      end
      3'd1: begin // I: 12-bit signed
        w_legal = (bus_if.imm == {{20{bus_if.imm[11]}}, bus_if.imm[11:0]});
        w_word  = {bus_if.imm[11:0], bus_if.rs1, bus_if.funct3,
                   bus_if.rd, bus_if.opcode};
      end
      3'd2: begin // S: 12-bit signed
        w_legal = (bus_if.imm == {{20{bus_if.imm[11]}}, bus_if.imm[11:0]});
        w_word  = {bus_if.imm[11:5], bus_if.rs2, bus_if.rs1, bus_if.funct3,
                   bus_if.imm[4:0], bus_if.opcode};
      end
      3'd3: begin // B: 13-bit signed, even
        w_legal = (bus_if.imm == {{19{bus_if.imm[12]}}, bus_if.imm[12:0]}) &&
                  !bus_if.imm[0];
        w_word  = {bus_if.imm[12], bus_if.imm[10:5], bus_if.rs2, bus_if.rs1,
                   bus_if.funct3, bus_if.imm[4:1], bus_if.imm[11],
                   bus_if.opcode};
      end
      3'd4: begin // U: upper 20 bits only
        w_legal = (bus_if.imm[11:0] == 12'h000);
        w_word  = {bus_if.imm[31:12], bus_if.rd, bus_if.opcode};
      end
      3'd5: begin // J: 21-bit signed, even
        w_legal = (bus_if.imm == {{11{bus_if.imm[20]}}, bus_if.imm[20:0]}) &&
                  !bus_if.imm[0];
        w_word  = {bus_if.imm[20], bus_if.imm[10:1], bus_if.imm[11],
                   bus_if.imm[19:12], bus_if.rd, bus_if.opcode};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = 32'h0;
      end
    endcase
  end

  // Next-state selection for the session FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (count_q == c_CNT_ZERO)  state_d = ST_DONE;
        else if (w_accept && w_last) state_d = ST_DONE;
      end
      ST_DONE: if (w_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Session state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Session bookkeeping, write-port registers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (w_start) begin
        ptr_q   <= bus_if.base_addr;
        cnt_q   <= '0;
        count_q <= bus_if.count;
        err_q   <= 1'b0;
      end
      if (w_accept) begin
        cnt_q <= cnt_q + c_CNT_ONE;
        if (w_legal) begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= w_word;
          ptr_q   <= ptr_q + c_PTR_STEP;
        end else begin
          err_q <= 1'b1;
        end
      end
      if ((state_q == ST_LOAD) && (state_d == ST_DONE)) done_q <= 1'b1;
    end
  end

  assign bus_if.busy      = w_busy;
  assign bus_if.in_ready  = w_busy;
  assign bus_if.mem_we    = we_q;
  assign bus_if.mem_addr  = addr_q;
  assign bus_if.mem_wdata = wdata_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;

endmodule
`default_nettype wire
